// File: rtl/regfile_op_sequencer.sv
// Multi-cycle command sequencer driving a register-file/ALU pair: IDLE -> READ -> EXEC -> WRITE.
// Optional overflow trap enabled by defining REGFILE_SEQ_OVF_TRAP_EN (adds the Trap output).
module regfile_op_sequencer #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          CmdValid,
  output logic          CmdReady,
  input  logic          CmdLoad,
  input  logic [3:0]    CmdOp,
  input  logic [AW-1:0] CmdRs,
  input  logic [AW-1:0] CmdRt,
  input  logic [AW-1:0] CmdRd,
  input  logic [4:0]    CmdShamt,
  input  logic [DW-1:0] CmdData,
  output logic [AW-1:0] RR1,
  output logic [AW-1:0] RR2,
  output logic [3:0]    AluOp,
  output logic [4:0]    ShiftCount,
  input  logic [DW-1:0] AluResult,
  input  logic          AluOverflow,
  output logic [AW-1:0] WR,
  output logic [DW-1:0] WD,
  output logic          WE,
  output logic          Done,
`ifdef REGFILE_SEQ_OVF_TRAP_EN
  output logic          Trap,
`endif
  output logic          Illegal
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] rr1_reg, rr2_reg, wr_reg;
  logic [3:0]    alu_op_reg;
  logic [4:0]    shamt_reg;
  logic [DW-1:0] wd_reg;
  logic          illegal_reg;
  logic          accept;

  assign accept = CmdValid && (state_reg == IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = CmdLoad ? WRITE : READ;
      READ:    state_next = EXEC;
      EXEC:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU controls only change when an ALU command is accepted, so loads leave them untouched
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rr1_reg     <= '0;
      rr2_reg     <= '0;
      alu_op_reg  <= '0;
      shamt_reg   <= '0;
      wr_reg      <= '0;
      wd_reg      <= '0;
      illegal_reg <= 1'b0;
    end else if (accept) begin
      wr_reg <= CmdRd;
      if (CmdLoad) begin
        wd_reg      <= CmdData;
        illegal_reg <= 1'b0;
      end else begin
        rr1_reg     <= CmdRs;
        rr2_reg     <= CmdRt;
        alu_op_reg  <= CmdOp;
        shamt_reg   <= CmdShamt;
        illegal_reg <= (CmdOp > 4'd8);
      end
    end else if (state_reg == EXEC) begin
      wd_reg <= AluResult;
    end
  end

`ifdef REGFILE_SEQ_OVF_TRAP_EN
  logic ovf_reg;

  // Cleared on every accept so a load never inherits a stale overflow
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)                  ovf_reg <= 1'b0;
    else if (accept)             ovf_reg <= 1'b0;
    else if (state_reg == EXEC)  ovf_reg <= AluOverflow && !illegal_reg;
  end

  assign Trap = (state_reg == WRITE) && ovf_reg;
  assign WE   = (state_reg == WRITE) && !illegal_reg && !ovf_reg;
`else
  logic unused_ovf;
  assign unused_ovf = AluOverflow;
  assign WE         = (state_reg == WRITE) && !illegal_reg;
`endif

  assign CmdReady   = (state_reg == IDLE);
  assign Done       = (state_reg == WRITE);
  assign Illegal    = (state_reg == WRITE) && illegal_reg;
  assign RR1        = rr1_reg;
  assign RR2        = rr2_reg;
  assign AluOp      = alu_op_reg;
  assign ShiftCount = shamt_reg;
  assign WR         = wr_reg;
  assign WD         = wd_reg;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: models the register file and ALU around the DUT, runs a vector
// table, hand-written handshake/reset sequences, then random commands against a reference model.
module tb_regfile_op_sequencer;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          CmdValid = 1'b0;
  logic          CmdReady;
  logic          CmdLoad = 1'b0;
  logic [3:0]    CmdOp = '0;
  logic [AW-1:0] CmdRs = '0, CmdRt = '0, CmdRd = '0;
  logic [4:0]    CmdShamt = '0;
  logic [DW-1:0] CmdData = '0;
  logic [AW-1:0] RR1, RR2, WR;
  logic [3:0]    AluOp;
  logic [4:0]    ShiftCount;
  logic [DW-1:0] AluResult;
  logic          AluOverflow;
  logic [DW-1:0] WD;
  logic          WE, Done, Illegal;
`ifdef REGFILE_SEQ_OVF_TRAP_EN
  logic          Trap;
`endif

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] rf    [32];
  logic [DW-1:0] model [32];

  always #5 Clk = ~Clk;

  regfile_op_sequencer #(.DW(DW), .AW(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdLoad(CmdLoad), .CmdOp(CmdOp), .CmdRs(CmdRs), .CmdRt(CmdRt), .CmdRd(CmdRd),
    .CmdShamt(CmdShamt), .CmdData(CmdData), .RR1(RR1), .RR2(RR2), .AluOp(AluOp),
    .ShiftCount(ShiftCount), .AluResult(AluResult), .AluOverflow(AluOverflow),
    .WR(WR), .WD(WD), .WE(WE), .Done(Done),
`ifdef REGFILE_SEQ_OVF_TRAP_EN
    .Trap(Trap),
`endif
    .Illegal(Illegal)
  );

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return 32'(sa + sb);
      4'd1: return 32'(sa - sb);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return 32'(longint'(a) * (longint'(1) << sh));
      4'd5: return 32'(longint'(a) / (longint'(1) << sh));
      4'd6: return 32'($floor(real'(sa) / real'(longint'(1) << sh)));
      4'd7: return (sa > sb) ? 32'd1 : 32'd0;
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ovf_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 4'd0)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  // Environment: combinational ALU fed from the register file read ports, synchronous write port
  always_comb begin
    AluResult   = alu_f(AluOp, rf[RR1], rf[RR2], ShiftCount);
    AluOverflow = ovf_f(AluOp, rf[RR1], rf[RR2]);
  end

  always @(posedge Clk) if (WE) rf[WR] <= WD;

  typedef struct {
    logic        load;
    logic [3:0]  op;
    logic [4:0]  rs, rt, rd, sh;
    logic [31:0] data, wd;
    logic        we, ill, trap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_v(input logic load, input logic [3:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                       input logic [31:0] data, input logic [31:0] wd,
                       input logic we, input logic ill, input logic trap);
    vec_t v;
    v.load = load; v.op = op; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
    v.data = data; v.wd = wd; v.we = we; v.ill = ill; v.trap = trap;
    vecs.push_back(v);
  endtask

  task automatic drive_cmd(input vec_t c);
    CmdLoad = c.load; CmdOp = c.op; CmdRs = c.rs; CmdRt = c.rt; CmdRd = c.rd;
    CmdShamt = c.sh; CmdData = c.data;
  endtask

  // Issue one command from an IDLE negedge and check its WRITE cycle and aftermath
  task automatic run_cmd(input vec_t c);
    int  cyc;
    bit  early_we;
    cyc = 0;
    while (!CmdReady && cyc < 10) begin @(negedge Clk); cyc++; end
    chk("ready_wait", 32'(CmdReady), 32'd1);
    drive_cmd(c);
    CmdValid = 1'b1;
    @(negedge Clk);
    CmdValid = 1'b0;
    cyc = 1;
    early_we = 1'b0;
    while (!Done && cyc < 8) begin
      if (WE) early_we = 1'b1;
      @(negedge Clk);
      cyc++;
    end
    chk("latency", 32'(cyc), c.load ? 32'd1 : 32'd3);
    chk("we_early", 32'(early_we), 32'd0);
    chk("done", 32'(Done), 32'd1);
    chk("we", 32'(WE), 32'(c.we));
    chk("illegal", 32'(Illegal), 32'(c.ill));
    if (c.we) begin
      chk("wr", 32'(WR), 32'(c.rd));
      chk("wd", WD, c.wd);
    end
`ifdef REGFILE_SEQ_OVF_TRAP_EN
    chk("trap", 32'(Trap), 32'(c.trap));
`endif
    $display("txn load=%0d op=%0d rs=%0d rt=%0d rd=%0d sh=%0d wd=%h we=%0d ill=%0d lat=%0d",
             c.load, c.op, c.rs, c.rt, c.rd, c.sh, WD, WE, Illegal, cyc);
    @(negedge Clk);
    chk("pulse_end", {29'd0, WE, Done, Illegal}, 32'd0);
    chk("ready_back", 32'(CmdReady), 32'd1);
    if (c.we) model[c.rd] = c.wd;
    chk("rf_content", rf[c.rd], model[c.rd]);
  endtask

  initial begin
    vec_t c;
    int   dones;
    for (int i = 0; i < 32; i++) begin rf[i] = '0; model[i] = '0; end

    // Reset values while Rst_n is held low
    #3;
    chk("rst_ready", 32'(CmdReady), 32'd1);
    chk("rst_flags", {29'd0, WE, Done, Illegal}, 32'd0);
    chk("rst_rr", {22'd0, RR1, RR2}, 32'd0);
    chk("rst_ctl", {18'd0, WR, AluOp, ShiftCount}, 32'd0);
    chk("rst_wd", WD, 32'd0);
    @(negedge Clk); @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    //    load op  rs  rt  rd  sh  data          wd            we ill trap
    add_v(1, 0,  0,  0,  0,  0,  32'hFFFFFFFE, 32'hFFFFFFFE, 1, 0, 0);
    add_v(1, 0,  0,  0,  1,  0,  32'd1200,     32'd1200,     1, 0, 0);
    add_v(0, 0,  0,  1,  2,  0,  32'd0,        32'd1198,     1, 0, 0);
    add_v(1, 0,  0,  0,  3,  0,  32'hFFFFF830, 32'hFFFFF830, 1, 0, 0);
    add_v(0, 1,  3,  0,  5,  0,  32'd0,        32'hFFFFF832, 1, 0, 0);
    add_v(0, 7,  0,  5,  6,  0,  32'd0,        32'd1,        1, 0, 0);
    add_v(0, 8,  0,  5,  7,  0,  32'd0,        32'd0,        1, 0, 0);
    add_v(0, 4,  0,  0,  8,  2,  32'd0,        32'hFFFFFFF8, 1, 0, 0);
    add_v(0, 5,  1,  0,  9,  3,  32'd0,        32'd150,      1, 0, 0);
    add_v(0, 6,  3,  0, 10,  4,  32'd0,        32'hFFFFFF83, 1, 0, 0);
    add_v(0, 2,  1,  0, 11,  0,  32'd0,        32'd1200,     1, 0, 0);
    add_v(0, 3,  1,  3, 12,  0,  32'd0,        32'hFFFFFCB0, 1, 0, 0);
    add_v(0, 12, 0,  1,  2,  0,  32'd0,        32'd0,        0, 1, 0);
    add_v(1, 0,  0,  0,  4,  0,  32'h7FFFFFFF, 32'h7FFFFFFF, 1, 0, 0);
    add_v(1, 0,  0,  0, 13,  0,  32'd1,        32'd1,        1, 0, 0);
`ifdef REGFILE_SEQ_OVF_TRAP_EN
    add_v(0, 0,  4, 13, 14,  0,  32'd0,        32'h80000000, 0, 0, 1);
`else
    add_v(0, 0,  4, 13, 14,  0,  32'd0,        32'h80000000, 1, 0, 0);
`endif
    foreach (vecs[i]) run_cmd(vecs[i]);
    chk("illegal_keeps_r2", rf[2], 32'd1198);

    // CmdValid held high across three add r0,r1->r15 commands
    c.load = 0; c.op = 0; c.rs = 0; c.rt = 1; c.rd = 15; c.sh = 0; c.data = 0;
    drive_cmd(c);
    CmdValid = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      chk("held_ready", 32'(CmdReady), (i % 4 == 3) ? 32'd1 : 32'd0);
      if (Done) begin
        dones++;
        chk("held_wd", WD, 32'd1198);
      end
    end
    CmdValid = 1'b0;
    $display("txn held-valid burst: dones=%0d", dones);
    chk("held_dones", 32'(dones), 32'd3);
    model[15] = 32'd1198;
    chk("held_rf", rf[15], 32'd1198);
    @(negedge Clk);

    // Async reset during EXEC of add r0,r1->r3 discards the command
    c.rd = 3;
    drive_cmd(c);
    CmdValid = 1'b1;
    @(negedge Clk);
    CmdValid = 1'b0;
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("rst_mid_we", 32'(WE), 32'd0);
    chk("rst_mid_done", 32'(Done), 32'd0);
    chk("rst_mid_ready", 32'(CmdReady), 32'd1);
    @(negedge Clk);
    chk("rst_mid_we_hold", 32'(WE), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("rst_rel_ready", 32'(CmdReady), 32'd1);
    chk("rst_rel_we", 32'(WE), 32'd0);
    chk("rst_rel_rf", rf[3], 32'hFFFFF830);
    $display("txn reset during EXEC: r3=%h", rf[3]);

    // Random commands against the reference model
    for (int n = 0; n < 60; n++) begin
      logic ov;
      c.load = ($urandom_range(0, 9) < 3);
      c.op   = 4'($urandom_range(0, 15));
      c.rs   = 5'($urandom_range(0, 31));
      c.rt   = 5'($urandom_range(0, 31));
      c.rd   = 5'($urandom_range(0, 31));
      c.sh   = 5'($urandom_range(0, 31));
      c.data = $urandom;
      c.trap = 1'b0;
      c.ill  = 1'b0;
      if (c.load) begin
        c.wd = c.data;
        c.we = 1'b1;
      end else if (c.op > 4'd8) begin
        c.wd  = 32'd0;
        c.we  = 1'b0;
        c.ill = 1'b1;
      end else begin
        c.wd = alu_f(c.op, model[c.rs], model[c.rt], c.sh);
        ov   = ovf_f(c.op, model[c.rs], model[c.rt]);
`ifdef REGFILE_SEQ_OVF_TRAP_EN
        c.we   = !ov;
        c.trap = ov;
`else
        c.we = 1'b1;
        ov   = 1'b0;
`endif
      end
      run_cmd(c);
    end

    for (int i = 0; i < 32; i++) chk("final_rf", rf[i], model[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
